// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode decoupling FIFO of {pc, instr} pairs
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_valid   fetch offers {in_pc, in_instr}
//   in_ready   queue accepts a pair this cycle (registered state only)
//   in_pc      offered instruction address
//   in_instr   offered instruction word
//   out_valid  head entry present
//   out_ready  decode consumes the head this cycle
//   out_pc     head entry address
//   out_instr  head entry instruction word
//   out_pc4    out_pc + 4 (wraps mod 2^32)
//   flush      discard every entry on the next edge
//   count      number of valid entries, 0..DEPTH
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_instr,
   output logic [31:0]      out_pc4,
   input  logic             flush,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

   logic [31:0]      r_pc_mem    [DEPTH];
   logic [31:0]      r_instr_mem [DEPTH];
   logic [PTR_W-1:0] r_wp;
   logic [PTR_W-1:0] r_rp;
   logic [PTR_W:0]   r_count;

   logic             w_push;
   logic             w_pop;

   // in_ready looks only at the stored count, so a full queue refuses a push
   // even when decode pops in the same cycle.
   assign in_ready  = rst && (r_count < C_FULL);
   assign out_valid = (r_count != '0);
   assign count     = r_count;

   // Flush wins over both handshakes; neither side sees a transfer complete.
   assign w_push = in_valid && in_ready && !flush;
   assign w_pop  = out_valid && out_ready && !flush;

   assign out_pc    = r_pc_mem[r_rp];
   assign out_instr = r_instr_mem[r_rp];
   assign out_pc4   = out_pc + 32'd4;

   // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wp <= r_wp + 1'b1;
         end
         if (w_pop) begin
            r_rp <= r_rp + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Storage is not reset; stale contents are masked by out_valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wp]    <= in_pc;
         r_instr_mem[r_wp] <= in_instr;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int PTR_W = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_pc;
   logic [31:0]      in_instr;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_pc;
   logic [31:0]      out_instr;
   logic [31:0]      out_pc4;
   logic             flush;
   logic [PTR_W:0]   count;

   int checks = 0;
   int errors = 0;

   logic [63:0] sb_q[$];

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_pc4   (out_pc4),
      .flush     (flush),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Check outputs against the scoreboard, then advance one clock and
   // update the scoreboard with the transfers the current drives imply.
   task automatic cycle();
      bit do_push;
      bit do_pop;
      logic [63:0] head;
      #1;
      chk("count", 32'(count), 32'(sb_q.size()));
      chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(rst && (sb_q.size() < DEPTH)));
      if (sb_q.size() != 0) begin
         head = sb_q[0];
         chk("out_pc", out_pc, head[63:32]);
         chk("out_instr", out_instr, head[31:0]);
         chk("out_pc4", out_pc4, head[63:32] + 32'd4);
      end
      do_push = rst && in_valid && (sb_q.size() < DEPTH) && !flush;
      do_pop  = rst && out_ready && (sb_q.size() != 0) && !flush;
      @(posedge clk);
      if (!rst || flush) begin
         sb_q.delete();
      end else begin
         if (do_pop) void'(sb_q.pop_front());
         if (do_push) sb_q.push_back({in_pc, in_instr});
      end
      #1;
   endtask

   task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] ins);
      in_valid = v;
      in_pc    = pc;
      in_instr = ins;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
      offer(1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;

      // reset held, then released
      cycle();
      cycle();
      rst = 1'b1;
      cycle();

      // fill with decode stalled
      for (int i = 0; i < 4; i++) begin
         offer(1'b1, 32'h0040_0000 + 32'(4*i), 32'h2008_0001 + 32'(i));
         cycle();
      end
      offer(1'b0, 32'h0, 32'h0);
      #1;
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      cycle();

      // drain in order
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      out_ready = 1'b0;
      cycle();

      // steady state at count 2 with push+pop every cycle
      for (int i = 0; i < 2; i++) begin
         offer(1'b1, 32'h0040_1000 + 32'(4*i), 32'hA000_0000 + 32'(i));
         cycle();
      end
      out_ready = 1'b1;
      for (int i = 2; i < 12; i++) begin
         offer(1'b1, 32'h0040_1000 + 32'(4*i), 32'hA000_0000 + 32'(i));
         cycle();
      end
      out_ready = 1'b0;
      #1;
      chk("steady_count", 32'(count), 32'd2);

      // refill to full
      for (int i = 0; i < 2; i++) begin
         offer(1'b1, 32'h0040_1800 + 32'(4*i), 32'hB000_0000 + 32'(i));
         cycle();
      end

      // full with pop: push refused, count drops to 3
      offer(1'b1, 32'h0040_2000, 32'hC000_0000);
      out_ready = 1'b1;
      cycle();
      offer(1'b0, 32'h0, 32'h0);
      out_ready = 1'b0;
      #1;
      chk("pop_full_count", 32'(count), 32'd3);
      chk("pop_full_in_ready", 32'(in_ready), 32'd1);
      cycle();

      // flush together with an offered pair
      flush = 1'b1;
      offer(1'b1, 32'h0040_0100, 32'hDEAD_0100);
      cycle();
      flush = 1'b0;
      offer(1'b0, 32'h0, 32'h0);
      #1;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      cycle();
      offer(1'b1, 32'h0040_0200, 32'h2008_0200);
      cycle();
      offer(1'b0, 32'h0, 32'h0);
      #1;
      chk("post_flush_pc", out_pc, 32'h0040_0200);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;

      // address wrap on pc + 4
      offer(1'b1, 32'hFFFF_FFFC, 32'h0000_000C);
      cycle();
      offer(1'b0, 32'h0, 32'h0);
      #1;
      chk("wrap_pc4", out_pc4, 32'h0000_0000);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;

      // random traffic
      for (int i = 0; i < 60; i++) begin
         offer(1'($urandom_range(0, 1)), 32'h0050_0000 + 32'(4*i), $urandom());
         out_ready = 1'($urandom_range(0, 1));
         flush = ($urandom_range(0, 19) == 0);
         cycle();
      end
      flush = 1'b0;

      // reset mid-stream
      out_ready = 1'b0;
      offer(1'b1, 32'h0060_0000, 32'h1111_1111);
      cycle();
      rst = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
      offer(1'b0, 32'h0, 32'h0);
      cycle();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
